// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC register, drives the instruction-memory
// request/response handshake and fills the IF/DE pipeline register.
// A one-entry buffer absorbs a word that returns while decode is stalled, and a
// DISCARD state swallows the stale response of a fetch that was redirected.
module if_fetch_stage #(
    parameter int              DW       = 32,
    parameter logic [DW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] pc_next,
    input  logic          stall,
    input  logic          flush,
    output logic [DW-1:0] pc_1,
    output logic          imem_req,
    output logic [DW-1:0] imem_addr,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic [DW-1:0] de_ir,
    output logic [DW-1:0] de_pc_1,
    output logic          de_valid
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t        state_q;
    logic [DW-1:0] pc_q;
    logic [DW-1:0] buf_q;
    logic [DW-1:0] old_addr_q;

    // PC+1 wraps naturally at 2^DW; it feeds both the mux and de_pc_1.
    assign pc_1 = pc_q + DW'(1);

    // A request is pending in every state except HOLD; DISCARD keeps presenting
    // the redirected address so the outstanding fetch stays stable until it returns.
    assign imem_req  = (state_q != HOLD);
    assign imem_addr = (state_q == DISCARD) ? old_addr_q : pc_q;

    // Fetch control, PC update and IF/DE register; flush outranks stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            buf_q      <= '0;
            old_addr_q <= '0;
            de_ir      <= '0;
            de_pc_1    <= '0;
            de_valid   <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (flush) begin
                        de_valid <= 1'b0;
                        pc_q     <= pc_next;
                        if (!imem_rvalid) begin
                            old_addr_q <= pc_q;
                            state_q    <= DISCARD;
                        end
                    end else if (imem_rvalid) begin
                        if (stall) begin
                            buf_q   <= imem_rdata;
                            state_q <= HOLD;
                        end else begin
                            de_ir    <= imem_rdata;
                            de_pc_1  <= pc_1;
                            de_valid <= 1'b1;
                            pc_q     <= pc_next;
                        end
                    end else if (!stall) begin
                        de_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        de_valid <= 1'b0;
                        pc_q     <= pc_next;
                        state_q  <= FETCH;
                    end else if (!stall) begin
                        de_ir    <= buf_q;
                        de_pc_1  <= pc_1;
                        de_valid <= 1'b1;
                        pc_q     <= pc_next;
                        state_q  <= FETCH;
                    end
                end
                DISCARD: begin
                    de_valid <= 1'b0;
                    if (flush) begin
                        pc_q <= pc_next;
                    end
                    if (imem_rvalid) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q  <= FETCH;
                    de_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: a latency-randomizing memory model and a
// transaction-level reference of the fetch stage predict every output each cycle.
module tb_if_fetch_stage;

    localparam int          DW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0010;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] pc_next;
    logic          stall;
    logic          flush;
    logic [DW-1:0] pc_1;
    logic          imem_req;
    logic [DW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic [DW-1:0] de_ir;
    logic [DW-1:0] de_pc_1;
    logic          de_valid;

    if_fetch_stage #(.DW(DW), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_next     (pc_next),
        .stall       (stall),
        .flush       (flush),
        .pc_1        (pc_1),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .de_ir       (de_ir),
        .de_pc_1     (de_pc_1),
        .de_valid    (de_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model: what the fetch stage is doing, in transaction terms
    logic [31:0] m_pc;
    bit          m_stale;        // an abandoned fetch is still in flight
    logic [31:0] m_stale_addr;
    bit          m_buf_valid;    // a word is parked waiting for decode
    logic [31:0] m_buf;
    bit          m_de_valid;
    logic [31:0] m_de_ir;
    logic [31:0] m_de_pc1;

    // memory model state and stimulus knobs
    bit          mem_busy;
    int          mem_lat;
    int          lat_max;
    int          stall_pct;
    int          flush_pct;
    int          rst_permil;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_stale = 0; m_stale_addr = '0;
        m_buf_valid = 0; m_buf = '0;
        m_de_valid = 0; m_de_ir = '0; m_de_pc1 = '0;
        mem_busy = 0; mem_lat = 0;
    endtask

    task automatic deliver(input logic [31:0] w, input logic [31:0] nxt);
        m_de_ir    = w;
        m_de_pc1   = m_pc + 32'd1;
        m_de_valid = 1;
        m_pc       = nxt;
    endtask

    task automatic model_step(input bit rs, input bit fl, input bit st, input bit rv,
                              input logic [31:0] rd, input logic [31:0] nxt);
        if (!rs) begin
            model_reset();
        end else if (m_stale) begin
            m_de_valid = 0;
            if (fl) m_pc = nxt;
            if (rv) m_stale = 0;
        end else if (m_buf_valid) begin
            if (fl) begin
                m_buf_valid = 0; m_de_valid = 0; m_pc = nxt;
            end else if (!st) begin
                m_buf_valid = 0;
                deliver(m_buf, nxt);
            end
        end else begin
            if (fl) begin
                m_de_valid = 0;
                if (!rv) begin m_stale = 1; m_stale_addr = m_pc; end
                m_pc = nxt;
            end else if (rv) begin
                if (st) begin m_buf = rd; m_buf_valid = 1; end
                else deliver(rd, nxt);
            end else if (!st) begin
                m_de_valid = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        check("pc_1", pc_1, m_pc + 32'd1);
        check("imem_req", {31'd0, imem_req}, {31'd0, !m_buf_valid});
        if (!m_buf_valid)
            check("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
        check("de_valid", {31'd0, de_valid}, {31'd0, m_de_valid});
        check("de_ir", de_ir, m_de_ir);
        check("de_pc_1", de_pc_1, m_de_pc1);
    endtask

    task automatic run_cycle();
        logic [31:0] tgt;
        @(negedge clk);
        compare_outputs();
        rst_n = !($urandom_range(0, 999) < rst_permil);
        stall = ($urandom_range(0, 99) < stall_pct);
        flush = ($urandom_range(0, 99) < flush_pct);
        case ($urandom_range(0, 3))
            0:       tgt = 32'hFFFF_FFFF;
            1:       tgt = 32'h0000_0200;
            2:       tgt = 32'hFFFF_FFFE;
            default: tgt = $urandom;
        endcase
        pc_next = flush ? tgt : m_pc + 32'd1;
        if (imem_req && !mem_busy) begin
            mem_busy = 1;
            mem_lat  = $urandom_range(0, lat_max);
        end
        if (rst_n && mem_busy && imem_req && mem_lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(imem_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (mem_busy && mem_lat > 0) mem_lat--;
        end
        @(posedge clk);
        model_step(rst_n, flush, stall, imem_rvalid, imem_rdata, pc_next);
        if (imem_rvalid || !rst_n) mem_busy = 0;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        pc_next = '0; imem_rvalid = 1'b0; imem_rdata = '0;
        lat_max = 0; stall_pct = 0; flush_pct = 0; rst_permil = 0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_req", {31'd0, imem_req}, 32'd1);
        check("rst_valid", {31'd0, de_valid}, 32'd0);
        check("rst_pc1", pc_1, RESET_PC + 32'd1);
        rst_n = 1'b1;

        // zero-wait memory, no stall: back-to-back sequential fetch
        repeat (20) run_cycle();
        check("stream_valid", {31'd0, de_valid}, 32'd1);

        // variable latency, no stall or flush
        lat_max = 2;
        repeat (200) run_cycle();

        // stalls only
        stall_pct = 40;
        repeat (400) run_cycle();

        // everything, including flushes near the wrap point and sporadic reset
        flush_pct = 15; rst_permil = 5;
        repeat (3000) run_cycle();

        // zero-wait with flushes, so wrap targets get delivered
        lat_max = 0; stall_pct = 10; flush_pct = 20; rst_permil = 2;
        repeat (1000) run_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
